// File: rtl/rng_stimulus_bank.sv
// Multi-channel Galois LFSR stimulus source with rate divider, burst sequencer
// and a MISR that folds a DUT response bus into a running signature.
module rng_stimulus_bank #(
   parameter int               NUM_CH   = 4,
   parameter int               WIDTH    = 64,
   parameter logic [WIDTH-1:0] POLY     = WIDTH'(64'hD800_0000_0000_0000),
   parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
   parameter int               DIV      = 1,
   parameter int               CNT_W    = 16,
   parameter int               SIG_W    = 64,
   parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(64'h1B)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [1:0]              i_mode,
   input  logic                    i_start,
   input  logic [CNT_W-1:0]        i_burst_len,
   input  logic [SIG_W-1:0]        i_capture_in,
   output logic [NUM_CH*WIDTH-1:0] o_random_number,
   output logic [SIG_W-1:0]        o_signature,
   output logic [CNT_W-1:0]        o_step_count,
   output logic                    o_busy,
   output logic                    o_done
);

   localparam int         DIV_W       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [1:0] MODE_FREE   = 2'd0;
   localparam logic [1:0] MODE_BURST  = 2'd2;
   localparam logic [1:0] MODE_RESEED = 2'd3;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e                         r_state;
   logic [CNT_W-1:0]               r_remaining;
   logic                           r_busy;
   logic                           r_done;
   logic [DIV_W-1:0]               r_div_cnt;
   logic [CNT_W-1:0]               r_step_count;
   logic [SIG_W-1:0]               r_sig;
   logic [NUM_CH-1:0][WIDTH-1:0]   r_lfsr;

   logic [NUM_CH-1:0][WIDTH-1:0]   w_seed;
   logic [NUM_CH-1:0][WIDTH-1:0]   w_lfsr_nxt;
   logic                           w_tick;
   logic                           w_reseed;
   logic                           w_advance;
   logic [SIG_W-1:0]               w_sig_nxt;

   // Per-channel seed is a constant; a zero seed would lock the LFSR, so it becomes all-ones.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam logic [WIDTH-1:0] SEED_SUM = SEED + WIDTH'(g);
      assign w_seed[g]     = (SEED_SUM == '0) ? '1 : SEED_SUM;
      assign w_lfsr_nxt[g] = r_lfsr[g][0] ? ((r_lfsr[g] >> 1) ^ POLY) : (r_lfsr[g] >> 1);
   end

   assign w_tick    = (r_div_cnt == DIV_W'(DIV - 1));
   assign w_reseed  = (i_mode == MODE_RESEED);
   assign w_advance = w_tick && ((i_mode == MODE_FREE) ||
                                 ((r_state == S_RUN) && (i_mode == MODE_BURST)));
   assign w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? SIG_POLY : '0) ^ i_capture_in;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div_cnt    <= '0;
         r_lfsr       <= w_seed;
         r_step_count <= '0;
         r_sig        <= '0;
      end else if (w_reseed) begin
         r_div_cnt    <= '0;
         r_lfsr       <= w_seed;
         r_step_count <= '0;
         r_sig        <= '0;
      end else begin
         r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
         r_sig     <= w_sig_nxt;
         if (w_advance) begin
            r_lfsr       <= w_lfsr_nxt;
            r_step_count <= r_step_count + CNT_W'(1);
         end
      end
   end

   // Burst sequencer: leaving BURST mode aborts silently, only the final advance pulses done.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_reseed) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if ((i_mode == MODE_BURST) && i_start && (i_burst_len != '0)) begin
                     r_remaining <= i_burst_len;
                     r_state     <= S_RUN;
                     r_busy      <= 1'b1;
                  end
               end
               S_RUN: begin
                  if (i_mode != MODE_BURST) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else if (w_advance) begin
                     if (r_remaining == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                     r_remaining <= r_remaining - CNT_W'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_random_number = r_lfsr;
   assign o_signature     = r_sig;
   assign o_step_count    = r_step_count;
   assign o_busy          = r_busy;
   assign o_done          = r_done;

endmodule

// File: tb/tb_rng_stimulus_bank.sv
// Scoreboard bench: two instances (DIV=1 and DIV=4) share one randomized stimulus
// stream; a behavioural model predicts each cycle and a negedge monitor compares.
module tb_rng_stimulus_bank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       start = 1'b0;
   logic [3:0] burst_len = 4'd0;
   logic [7:0] capture = 8'd0;

   logic [15:0] rn_a, rn_b;
   logic [7:0]  sig_a, sig_b;
   logic [3:0]  st_a, st_b;
   logic        busy_a, busy_b, done_a, done_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rng_stimulus_bank #(.NUM_CH(2), .WIDTH(8), .POLY(8'hB8), .SEED(8'd1), .DIV(1),
                       .CNT_W(4), .SIG_W(8), .SIG_POLY(8'h1D)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_start(start),
      .i_burst_len(burst_len), .i_capture_in(capture),
      .o_random_number(rn_a), .o_signature(sig_a), .o_step_count(st_a),
      .o_busy(busy_a), .o_done(done_a));

   rng_stimulus_bank #(.NUM_CH(2), .WIDTH(8), .POLY(8'hB8), .SEED(8'd1), .DIV(4),
                       .CNT_W(4), .SIG_W(8), .SIG_POLY(8'h1D)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_start(start),
      .i_burst_len(burst_len), .i_capture_in(capture),
      .o_random_number(rn_b), .o_signature(sig_b), .o_step_count(st_b),
      .o_busy(busy_b), .o_done(done_b));

   // Model state: channel values, advance count, signature, divider phase, burst advances left.
   typedef struct {
      logic [1:0][7:0] ch;
      int              steps;
      logic [7:0]      sig;
      int              phase;
      int              rem;
      bit              done;
   } mdl_t;

   typedef struct {
      logic [15:0] rn_a, rn_b;
      logic [7:0]  sig_a, sig_b;
      logic [3:0]  st_a, st_b;
      logic        busy_a, busy_b, done_a, done_b;
   } exp_t;

   exp_t q[$];
   mdl_t ma, mb;

   function automatic logic [7:0] lfsr(logic [7:0] s);
      return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
   endfunction

   function automatic mdl_t mreset();
      mdl_t m;
      m.ch[0] = 8'h01;
      m.ch[1] = 8'h02;
      m.steps = 0;
      m.sig   = 8'h00;
      m.phase = 0;
      m.rem   = 0;
      m.done  = 0;
      return m;
   endfunction

   function automatic mdl_t mstep(mdl_t m, int div, logic [1:0] md, bit st, int bl,
                                  logic [7:0] cap);
      bit tick, adv, run;
      if (md == 2'd3) return mreset();
      m.done  = 0;
      tick    = (m.phase == div - 1);
      m.phase = (m.phase + 1) % div;
      run     = (m.rem > 0);
      adv     = tick && (md == 2'd0 || (run && md == 2'd2));
      if (adv) begin
         m.ch[0] = lfsr(m.ch[0]);
         m.ch[1] = lfsr(m.ch[1]);
         m.steps = (m.steps + 1) % 16;
      end
      if (run) begin
         if (md != 2'd2) m.rem = 0;
         else if (adv) begin
            m.rem = m.rem - 1;
            if (m.rem == 0) m.done = 1;
         end
      end else if (md == 2'd2 && st && bl != 0) begin
         m.rem = bl;
      end
      m.sig = 8'((m.sig * 2) % 256) ^ (m.sig[7] ? 8'h1D : 8'h00) ^ cap;
      return m;
   endfunction

   task automatic push();
      exp_t e;
      e.rn_a   = ma.ch;
      e.rn_b   = mb.ch;
      e.sig_a  = ma.sig;
      e.sig_b  = mb.sig;
      e.st_a   = 4'(ma.steps);
      e.st_b   = 4'(mb.steps);
      e.busy_a = (ma.rem > 0);
      e.busy_b = (mb.rem > 0);
      e.done_a = ma.done;
      e.done_b = mb.done;
      q.push_back(e);
   endtask

   task automatic cyc(input logic [1:0] md, input bit st, input int bl, input logic [7:0] cap);
      @(negedge clk);
      #1;
      rst_n     = 1'b1;
      mode      = md;
      start     = st;
      burst_len = 4'(bl);
      capture   = cap;
      ma = mstep(ma, 1, md, st, bl, cap);
      mb = mstep(mb, 4, md, st, bl, cap);
      push();
   endtask

   // Reset is asserted shortly after a rising edge and sampled before the next one.
   task automatic async_reset();
      @(negedge clk);
      #1;
      rst_n   = 1'b1;
      mode    = 2'd0;
      start   = 1'b0;
      capture = 8'($urandom);
      ma = mreset();
      mb = mreset();
      push();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("rn_a",   rn_a,          e.rn_a);
         chk("rn_b",   rn_b,          e.rn_b);
         chk("sig_a",  16'(sig_a),    16'(e.sig_a));
         chk("sig_b",  16'(sig_b),    16'(e.sig_b));
         chk("step_a", 16'(st_a),     16'(e.st_a));
         chk("step_b", 16'(st_b),     16'(e.st_b));
         chk("busy_a", 16'(busy_a),   16'(e.busy_a));
         chk("busy_b", 16'(busy_b),   16'(e.busy_b));
         chk("done_a", 16'(done_a),   16'(e.done_a));
         chk("done_b", 16'(done_b),   16'(e.done_b));
      end
   end

   initial begin
      ma = mreset();
      mb = mreset();
      #1;
      push();
      // Free run with a known capture sequence, then random captures.
      cyc(2'd0, 0, 0, 8'h01);
      cyc(2'd0, 0, 0, 8'h00);
      cyc(2'd0, 0, 0, 8'h00);
      for (int i = 0; i < 10; i++) cyc(2'd0, 0, 0, 8'($urandom));
      for (int i = 0; i < 10; i++) cyc(2'd1, 0, 0, 8'($urandom));
      // Reseed, then walk the signature through 80 -> 1D while frozen.
      cyc(2'd3, 1, 3, 8'($urandom));
      cyc(2'd1, 0, 0, 8'h80);
      cyc(2'd1, 0, 0, 8'h00);
      // Burst of 3, long enough for the slow divider to finish too.
      cyc(2'd2, 1, 3, 8'($urandom));
      for (int i = 0; i < 14; i++) cyc(2'd2, 0, 0, 8'($urandom));
      // Zero-length burst is ignored.
      cyc(2'd2, 1, 0, 8'($urandom));
      for (int i = 0; i < 4; i++) cyc(2'd2, 0, 0, 8'($urandom));
      // Abort by switching to HOLD mid-burst.
      cyc(2'd2, 1, 5, 8'($urandom));
      cyc(2'd2, 1, 2, 8'($urandom));
      cyc(2'd1, 0, 0, 8'($urandom));
      for (int i = 0; i < 3; i++) cyc(2'd2, 0, 0, 8'($urandom));
      // Step counter wrap.
      for (int i = 0; i < 40; i++) cyc(2'd0, 0, 0, 8'($urandom));
      // Asynchronous reset in the middle of a burst.
      cyc(2'd2, 1, 7, 8'($urandom));
      cyc(2'd2, 0, 0, 8'($urandom));
      cyc(2'd2, 0, 0, 8'($urandom));
      async_reset();
      for (int i = 0; i < 6; i++) cyc(2'd2, 0, 0, 8'($urandom));
      // Randomized mix of modes, starts and lengths.
      for (int i = 0; i < 400; i++) begin
         int r;
         logic [1:0] md;
         r  = int'($urandom_range(0, 15));
         md = (r < 6) ? 2'd0 : (r < 9) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
         if (i % 97 == 50) async_reset();
         else cyc(md, bit'($urandom_range(0, 1)), int'($urandom_range(0, 6)), 8'($urandom));
      end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
